k_msg_serializer: RTL and testbench
===================================

# k_msg_serializer

Transmit-side counterpart of the stage-5 field extractors. Accepts one "k" message as parallel fields OP1..OP4 and emits it as a byte stream (type byte, then fields MSB-first) on a valid/ready interface toward the outbound link framer. Sits at the end of the order/response path, after field formatting and before the MAC-side framer.

## Interface
- `FIELD_BITS`, 32, width of each of OP1..OP4; must be a multiple of 8.
- `TYPE_CODE`, 8'h6B, header byte emitted first; the "k" message type code.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fld_valid`  in  1  field set presented.
- `fld_ready`  out  1  serializer can accept a field set.
- `op1`..`op4`  in  FIELD_BITS each  field values; sampled on load.
- `tx_data`  out  8  stream byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  downstream accepts byte.
- `tx_sop` / `tx_eop`  out  1 each  first / last byte of message.
- `busy`  out  1  message in flight.
- `msg_count`  out  16  messages fully sent; wraps 0xFFFF -> 0x0000.

## Operation
- Load: `fld_valid && fld_ready` captures op1..op4 into a 4*FIELD_BITS shift register; FSM leaves IDLE.
- FSM states: IDLE -> HDR -> BODY -> (CSUM if enabled) -> IDLE.
  - IDLE: `fld_ready`=1, `tx_valid`=0.
  - HDR: `tx_data`=TYPE_CODE, `tx_sop`=1; advance on `tx_ready`.
  - BODY: bytes op1[MSB byte]..op4[LSB byte], big-endian, 4*FIELD_BITS/8 bytes; byte counter increments per accepted byte; last body byte raises `tx_eop` when checksum disabled.
  - CSUM: one checksum byte, `tx_eop`=1.
- Handshake: byte transfers when `tx_valid && tx_ready`. Once `tx_valid` is high, `tx_data`, `tx_sop`, `tx_eop` hold stable until accepted. `tx_valid` never drops without a transfer.
- `fld_ready` = (state==IDLE) only; no back-to-back overlap. `op*` ignored outside load cycle.
- `busy` = state != IDLE.
- `msg_count` increments in the cycle the eop byte transfers.
- Reset (any time, including mid-message): state IDLE, shift register and counters zero, all outputs 0 except `fld_ready`=1 after reset deasserts; partial message is dropped, no eop emitted, `msg_count` not incremented.

## Timing
- Load at edge N -> `tx_valid`=1 with header from cycle N+1.
- With `tx_ready` held high: message occupies 1 + 4*FIELD_BITS/8 (+1 checksum) consecutive cycles; default 17 (18).
- `fld_ready` returns high the cycle after the eop transfer; earliest next header is 2 cycles after eop.
- `tx_ready` low stalls indefinitely with no data loss.

## Configuration
- `K_MSG_CHECKSUM_EN` defined: CSUM state present; checksum = XOR of header and all body bytes; `tx_eop` on checksum byte; message length +1.
- Not defined: no CSUM state, no accumulator logic; `tx_eop` on last body byte.

## Structure
- Shared package `k_msg_pkg`: state encoding, TYPE_CODE default, body byte count derived from FIELD_BITS, counter widths.
- One sub-module `k_msg_xor_acc`: 8-bit XOR accumulator with clear/enable, instantiated only under `K_MSG_CHECKSUM_EN`.

## Test plan
- Reset then idle: all outputs 0, `fld_ready`=1, `msg_count`=0.
- op1..op4 = 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10, `tx_ready`=1 -> bytes 0x6B,0x01..0x10; sop on 0x6B; eop on 0x10 (no checksum) or on extra byte 0x7B (checksum enabled); `msg_count`=1.
- Same message with `tx_ready` toggling 1,0,0,1,... -> identical byte sequence, `tx_data` stable through stalls.
- `fld_valid` held high with new fields during transmission -> ignored; second set loaded only after `fld_ready` returns, sent intact.
- Assert `rst_n` low after 5th byte -> outputs 0 immediately; next message starts cleanly with header 0x6B; `msg_count` unchanged.
- Force `msg_count`=0xFFFF (send 65535 messages or preload via test hook), send one -> wraps to 0x0000.

Source files
------------

// File: rtl/k_msg_pkg.sv
// Shared definitions for the "k" message serializer: state encoding, defaults,
// and body-length helpers derived from the field width.
package k_msg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_BODY = 2'd2,
      ST_CSUM = 2'd3
   } k_state_t;

   localparam int unsigned K_FIELD_BITS = 32;
   localparam logic [7:0]  K_TYPE_CODE  = 8'h6B;
   localparam int unsigned K_MSG_CNT_W  = 16;

   function automatic int unsigned body_bytes(input int unsigned field_bits);
      return (4 * field_bits) / 8;
   endfunction

   function automatic int unsigned byte_cnt_w(input int unsigned field_bits);
      return $clog2(body_bytes(field_bits));
   endfunction

endpackage

// File: rtl/k_msg_xor_acc.sv
// 8-bit XOR accumulator with synchronous clear and enable; builds the
// message checksum byte.
module k_msg_xor_acc (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] acc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc ^ din;
      end
   end

endmodule

// File: rtl/k_msg_serializer.sv
// Serializes one "k" message (OP1..OP4) into a valid/ready byte stream:
// type byte, then fields MSB-first. Optional trailing XOR checksum under K_MSG_CHECKSUM_EN.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for a field set, fld_ready high
// ST_HDR  | presenting TYPE_CODE with tx_sop
// ST_BODY | presenting body bytes from the top of the shift register
// ST_CSUM | presenting checksum byte with tx_eop (checksum builds only)
module k_msg_serializer
   import k_msg_pkg::*;
#(
   parameter int unsigned             FIELD_BITS    = K_FIELD_BITS,
   parameter logic [7:0]              TYPE_CODE     = K_TYPE_CODE,
   // Reset value of msg_count; nonzero only to exercise the wrap without 64k messages.
   parameter logic [K_MSG_CNT_W-1:0]  MSG_COUNT_RST = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    fld_valid,
   output logic                    fld_ready,
   input  logic [FIELD_BITS-1:0]   op1,
   input  logic [FIELD_BITS-1:0]   op2,
   input  logic [FIELD_BITS-1:0]   op3,
   input  logic [FIELD_BITS-1:0]   op4,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic                    tx_sop,
   output logic                    tx_eop,
   output logic                    busy,
   output logic [K_MSG_CNT_W-1:0]  msg_count
);

   localparam int unsigned     BODY_BYTES = body_bytes(FIELD_BITS);
   localparam int unsigned     BC_W       = byte_cnt_w(FIELD_BITS);
   localparam int unsigned     SR_W       = 4 * FIELD_BITS;
   localparam logic [BC_W-1:0] LAST_IDX   = BC_W'(BODY_BYTES - 1);

   k_state_t               state_q;
   k_state_t               state_d;
   logic [SR_W-1:0]        shreg_q;
   logic [BC_W-1:0]        byte_cnt_q;
   logic [K_MSG_CNT_W-1:0] msg_count_q;
   logic                   load;
   logic                   xfer;
   logic                   last_body;

   assign fld_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign msg_count = msg_count_q;
   assign load      = fld_valid && fld_ready;
   assign xfer      = tx_valid && tx_ready;
   assign last_body = (state_q == ST_BODY) && (byte_cnt_q == LAST_IDX);

`ifdef K_MSG_CHECKSUM_EN
   logic [7:0] csum;

   k_msg_xor_acc u_xor_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (load),
      .en    (xfer && ((state_q == ST_HDR) || (state_q == ST_BODY))),
      .din   (tx_data),
      .acc   (csum)
   );
`endif

   always_comb begin
      state_d  = state_q;
      tx_valid = 1'b0;
      tx_data  = '0;
      tx_sop   = 1'b0;
      tx_eop   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load) state_d = ST_HDR;
         end
         ST_HDR: begin
            tx_valid = 1'b1;
            tx_data  = TYPE_CODE;
            tx_sop   = 1'b1;
            if (tx_ready) state_d = ST_BODY;
         end
         ST_BODY: begin
            tx_valid = 1'b1;
            tx_data  = shreg_q[SR_W-1 -: 8];
`ifdef K_MSG_CHECKSUM_EN
            if (tx_ready && last_body) state_d = ST_CSUM;
`else
            tx_eop   = last_body;
            if (tx_ready && last_body) state_d = ST_IDLE;
`endif
         end
         ST_CSUM: begin
`ifdef K_MSG_CHECKSUM_EN
            tx_valid = 1'b1;
            tx_data  = csum;
            tx_eop   = 1'b1;
            if (tx_ready) state_d = ST_IDLE;
`else
            state_d  = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         shreg_q     <= '0;
         byte_cnt_q  <= '0;
         msg_count_q <= MSG_COUNT_RST;
      end else begin
         state_q <= state_d;
         if (load) begin
            shreg_q    <= {op1, op2, op3, op4};
            byte_cnt_q <= '0;
         end else if (xfer && (state_q == ST_BODY)) begin
            shreg_q    <= {shreg_q[SR_W-9:0], 8'h00};
            byte_cnt_q <= byte_cnt_q + BC_W'(1);
         end
         if (xfer && tx_eop) msg_count_q <= msg_count_q + K_MSG_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_k_msg_serializer.sv
// Randomized self-checking bench for k_msg_serializer; expected byte stream
// is built from the message layout rules (header, big-endian fields, optional XOR).
module tb_k_msg_serializer;

   localparam int FB      = 32;
   localparam int NB      = 4 * FB / 8;
`ifdef K_MSG_CHECKSUM_EN
   localparam int MSG_LEN = NB + 2;
`else
   localparam int MSG_LEN = NB + 1;
`endif
   localparam int BUDGET  = 400;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fld_valid = 1'b0;
   logic          fld_ready;
   logic [FB-1:0] op1 = '0, op2 = '0, op3 = '0, op4 = '0;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready = 1'b0;
   logic          tx_sop, tx_eop, busy;
   logic [15:0]   msg_count;

   logic          w_fld_valid = 1'b0;
   logic          w_fld_ready;
   logic [7:0]    w_tx_data;
   logic          w_tx_valid, w_tx_sop, w_tx_eop, w_busy;
   logic [15:0]   w_msg_count;

   always #5 clk = ~clk;

   k_msg_serializer u_dut (
      .clk(clk), .rst_n(rst_n), .fld_valid(fld_valid), .fld_ready(fld_ready),
      .op1(op1), .op2(op2), .op3(op3), .op4(op4),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_sop(tx_sop), .tx_eop(tx_eop), .busy(busy), .msg_count(msg_count)
   );

   k_msg_serializer #(.MSG_COUNT_RST(16'hFFFF)) u_dut_wrap (
      .clk(clk), .rst_n(rst_n), .fld_valid(w_fld_valid), .fld_ready(w_fld_ready),
      .op1(32'hA1B2C3D4), .op2(32'h11223344), .op3(32'h55667788), .op4(32'h99AABBCC),
      .tx_data(w_tx_data), .tx_valid(w_tx_valid), .tx_ready(1'b1),
      .tx_sop(w_tx_sop), .tx_eop(w_tx_eop), .busy(w_busy), .msg_count(w_msg_count)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_count = '0;
   logic [7:0]  exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic build_expected(input logic [FB-1:0] a, b, c, d);
      logic [FB-1:0] ops[4];
      logic [7:0]    x;
      ops = '{a, b, c, d};
      exp_q.delete();
      exp_q.push_back(8'h6B);
      for (int f = 0; f < 4; f++)
         for (int k = FB/8 - 1; k >= 0; k--)
            exp_q.push_back(8'((ops[f] >> (8 * k)) & 32'hFF));
`ifdef K_MSG_CHECKSUM_EN
      x = '0;
      foreach (exp_q[i]) x = x ^ exp_q[i];
      exp_q.push_back(x);
`endif
   endtask

   function automatic logic ready_pat(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return (cyc % 3) == 0;
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // mode: tx_ready pattern; hold: keep fld_valid high with junk during the message and
   // present nxt_* at the end; skip_wait: fields already presented at the current negedge.
   task automatic send_msg(input logic [FB-1:0] a, b, c, d, input int mode,
                           input bit hold, input logic [FB-1:0] na, nb, nc, nd,
                           input bit skip_wait, input int abort_after);
      int         idx, cyc;
      bit         stalled;
      logic [7:0] p_data;
      logic       p_sop, p_eop;
      build_expected(a, b, c, d);
      if (!skip_wait) @(negedge clk);
      fld_valid = 1'b1;
      op1 = a; op2 = b; op3 = c; op4 = d;
      chk("fld_ready_before_load", fld_ready, 1);
      @(negedge clk);
      idx = 0; cyc = 0; stalled = 0; p_data = '0; p_sop = 0; p_eop = 0;
      while (idx < exp_q.size()) begin
         if (abort_after > 0 && idx == abort_after) begin
            rst_n = 1'b0;
            fld_valid = 1'b0;
            #1;
            chk("abort_tx_valid", tx_valid, 0);
            chk("abort_tx_data", tx_data, 0);
            chk("abort_sop_eop", {tx_sop, tx_eop}, 0);
            chk("abort_busy", busy, 0);
            chk("abort_msg_count", msg_count, 0);
            exp_count = '0;
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            chk("abort_fld_ready", fld_ready, 1);
            return;
         end
         if (cyc > BUDGET) begin
            chk("msg_done_in_budget", idx, exp_q.size());
            fld_valid = 1'b0;
            return;
         end
         if (hold) begin
            fld_valid = 1'b1;
            op1 = $urandom; op2 = $urandom; op3 = $urandom; op4 = $urandom;
         end else begin
            fld_valid = 1'b0;
         end
         tx_ready = ready_pat(mode, cyc);
         #1;
         if (cyc == 0) chk("valid_after_load", tx_valid, 1);
         chk("fld_ready_in_flight", fld_ready, 0);
         chk("busy_in_flight", busy, 1);
         if (stalled) begin
            chk("stall_valid", tx_valid, 1);
            chk("stall_data", tx_data, p_data);
            chk("stall_flags", {tx_sop, tx_eop}, {p_sop, p_eop});
         end
         if (tx_valid && tx_ready) begin
            chk("byte", tx_data, exp_q[idx]);
            chk("sop", tx_sop, idx == 0);
            chk("eop", tx_eop, idx == exp_q.size() - 1);
            idx++;
         end
         stalled = tx_valid && !tx_ready;
         p_data = tx_data; p_sop = tx_sop; p_eop = tx_eop;
         @(negedge clk);
         cyc++;
      end
      exp_count = exp_count + 16'd1;
      if (mode == 0) chk("msg_len_cycles", cyc, MSG_LEN);
      chk("msg_count", msg_count, exp_count);
      chk("fld_ready_after_eop", fld_ready, 1);
      chk("busy_after_eop", busy, 0);
      chk("tx_valid_after_eop", tx_valid, 0);
      if (hold) begin
         fld_valid = 1'b1;
         op1 = na; op2 = nb; op3 = nc; op4 = nd;
      end else begin
         fld_valid = 1'b0;
      end
   endtask

   initial begin
      bit seen;
      #12;
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_sop_eop", {tx_sop, tx_eop}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_msg_count", msg_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("idle_fld_ready", fld_ready, 1);
      chk("idle_tx_valid", tx_valid, 0);
      chk("wrap_preload", w_msg_count, 16'hFFFF);

      // abort after the 5th byte, then a clean message
      send_msg(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 0, 0,
               '0, '0, '0, '0, 0, 5);
      send_msg(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 0, 0,
               '0, '0, '0, '0, 0, 0);
      send_msg(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 1, 0,
               '0, '0, '0, '0, 0, 0);
      send_msg(32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF, 32'h80000001, 2, 1,
               32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 0, 0);
      send_msg(32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 2, 0,
               '0, '0, '0, '0, 1, 0);
      for (int i = 0; i < 8; i++)
         send_msg($urandom, $urandom, $urandom, $urandom, (i % 2 == 0) ? 2 : 0, 0,
                  '0, '0, '0, '0, 0, 0);

      // counter wrap on the preloaded instance
      @(negedge clk);
      w_fld_valid = 1'b1;
      @(negedge clk);
      w_fld_valid = 1'b0;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (w_tx_valid && w_tx_eop) seen = 1;
         @(negedge clk);
      end
      chk("wrap_eop_seen", seen, 1);
      chk("wrap_msg_count", w_msg_count, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
